// File: rtl/udp_ip_encoder.sv
// udp_ip_encoder
// Builds one IPv4 datagram carrying UDP as a stream of 32-bit words in network
// byte order: 5 IPv4 header words (IHL=5), 2 UDP header words, then
// ceil(len_data/4) payload words taken from a first-word-fall-through FIFO.
// The IPv4 header checksum is computed in a dedicated cycle before the header
// is sent. The UDP checksum is sent as 0x0000, meaning "not used" on IPv4.
//
// Ports
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start           request; header fields are latched when accepted in IDLE
//   src_ip/dest_ip  IPv4 addresses
//   src_port/dest_port, identification, time_to_live, len_data  header fields
//   data_in         FIFO head word, consumed whenever rd_en=1
//   rd_en           pops one payload word
//   data_out/wr_en  datagram word and its valid strobe
//   busy            a datagram is in progress
//   fin             marks the last datagram word
//   err             one-cycle pulse when a start is rejected (payload too long)
module udp_ip_encoder #(
    parameter int         MAX_DATA_LEN = 1472,
    parameter logic [7:0] TOS          = 8'h00,
    parameter bit         DF           = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] src_ip,
    input  logic [31:0] dest_ip,
    input  logic [15:0] src_port,
    input  logic [15:0] dest_port,
    input  logic [15:0] identification,
    input  logic [7:0]  time_to_live,
    input  logic [15:0] len_data,
    input  logic [31:0] data_in,
    output logic        rd_en,
    output logic [31:0] data_out,
    output logic        wr_en,
    output logic        busy,
    output logic        fin,
    output logic        err
);

    localparam logic [15:0] MAX_LEN = 16'(MAX_DATA_LEN);
    localparam logic [2:0]  FLAGS   = DF ? 3'b010 : 3'b000;

    typedef enum logic [2:0] {IDLE, CSUM, IP_HDR, UDP_HDR, PAYLOAD} state_t;

    state_t      state, next_state;

    logic [31:0] src_ip_q, dest_ip_q;
    logic [15:0] src_port_q, dest_port_q, id_q, len_q;
    logic [7:0]  ttl_q;
    logic [15:0] hdr_csum;
    logic [15:0] pay_left;
    logic [2:0]  word_idx;
    logic        err_q;

    logic        accept, reject;
    logic [15:0] total_length, udp_length, pay_words;
    logic [19:0] csum_raw;
    logic [16:0] csum_fold1;
    logic [15:0] csum_fold2;
    logic [31:0] last_mask;

    assign accept       = (state == IDLE) && start && (len_data <= MAX_LEN);
    assign reject       = (state == IDLE) && start && (len_data > MAX_LEN);
    assign total_length = len_q + 16'd28;
    assign udp_length   = len_q + 16'd8;
    // Widened by one bit so the round-up cannot wrap for any 16-bit length.
    assign pay_words    = 16'((17'(len_data) + 17'd3) >> 2);

    // Nine non-zero header halfwords (checksum field taken as 0); 20 bits hold
    // the worst-case sum, two folds bring every carry back into 16 bits.
    assign csum_raw = 20'({4'd4, 4'd5, TOS}) + 20'(total_length) + 20'(id_q)
                    + 20'({FLAGS, 13'd0}) + 20'({ttl_q, 8'd17})
                    + 20'(src_ip_q[31:16]) + 20'(src_ip_q[15:0])
                    + 20'(dest_ip_q[31:16]) + 20'(dest_ip_q[15:0]);
    assign csum_fold1 = 17'(csum_raw[15:0]) + 17'(csum_raw[19:16]);
    assign csum_fold2 = csum_fold1[15:0] + 16'(csum_fold1[16]);

    // Keeps the len%4 leading bytes of the final payload word; 0 keeps all four.
    always_comb begin
        last_mask = 32'hFFFF_FFFF;
        case (len_q[1:0])
            2'd1:    last_mask = 32'hFF00_0000;
            2'd2:    last_mask = 32'hFFFF_0000;
            2'd3:    last_mask = 32'hFFFF_FF00;
            default: last_mask = 32'hFFFF_FFFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            src_ip_q    <= '0;
            dest_ip_q   <= '0;
            src_port_q  <= '0;
            dest_port_q <= '0;
            id_q        <= '0;
            ttl_q       <= '0;
            len_q       <= '0;
            hdr_csum    <= '0;
            pay_left    <= '0;
            word_idx    <= '0;
            err_q       <= 1'b0;
        end else begin
            state <= next_state;
            err_q <= reject;
            case (state)
                IDLE: begin
                    if (accept) begin
                        src_ip_q    <= src_ip;
                        dest_ip_q   <= dest_ip;
                        src_port_q  <= src_port;
                        dest_port_q <= dest_port;
                        id_q        <= identification;
                        ttl_q       <= time_to_live;
                        len_q       <= len_data;
                        pay_left    <= pay_words;
                        word_idx    <= 3'd0;
                    end
                end
                CSUM: begin
                    hdr_csum <= ~csum_fold2;
                    word_idx <= 3'd0;
                end
                IP_HDR:  word_idx <= (word_idx == 3'd4) ? 3'd0 : word_idx + 3'd1;
                UDP_HDR: word_idx <= word_idx + 3'd1;
                PAYLOAD: pay_left <= pay_left - 16'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        data_out   = '0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        fin        = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (accept) next_state = CSUM;
            end
            CSUM: next_state = IP_HDR;
            IP_HDR: begin
                wr_en = 1'b1;
                case (word_idx)
                    3'd0:    data_out = {4'd4, 4'd5, TOS, total_length};
                    3'd1:    data_out = {id_q, FLAGS, 13'd0};
                    3'd2:    data_out = {ttl_q, 8'd17, hdr_csum};
                    3'd3:    data_out = src_ip_q;
                    default: data_out = dest_ip_q;
                endcase
                if (word_idx == 3'd4) next_state = UDP_HDR;
            end
            UDP_HDR: begin
                wr_en = 1'b1;
                if (word_idx == 3'd0) begin
                    data_out = {src_port_q, dest_port_q};
                end else begin
                    data_out = {udp_length, 16'h0000};
                    // An empty payload ends the datagram on the UDP length word.
                    if (pay_left == 16'd0) begin
                        fin        = 1'b1;
                        next_state = IDLE;
                    end else begin
                        next_state = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                wr_en    = 1'b1;
                rd_en    = 1'b1;
                data_out = data_in;
                if (pay_left == 16'd1) begin
                    data_out   = data_in & last_mask;
                    fin        = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign err = err_q;

endmodule

// File: tb/tb_udp_ip_encoder.sv
// tb_udp_ip_encoder
// Drives udp_ip_encoder with fixed vectors, hand-written corner sequences and
// random datagrams. A FWFT FIFO model feeds data_in; expected word streams
// come from a table of constants or from a datagram-level reference model.
module tb_udp_ip_encoder;

    typedef struct {
        logic [31:0] src_ip;
        logic [31:0] dest_ip;
        logic [15:0] src_port;
        logic [15:0] dest_port;
        logic [15:0] identification;
        logic [7:0]  ttl;
        logic [15:0] len;
    } hdr_t;

    typedef struct {
        string           name;
        logic [15:0]     len;
        int              n_pay;
        logic [1:0][31:0] pay;
        int              n_words;
        logic [8:0][31:0] exp;
        int              exp_rd;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [31:0] src_ip, dest_ip, data_in, data_out;
    logic [15:0] src_port, dest_port, identification, len_data;
    logic [7:0]  time_to_live;
    logic        rd_en, wr_en, busy, fin, err;

    int checks   = 0;
    int failures = 0;

    logic [31:0] fifo[$];
    logic [31:0] pay_q[$];
    logic [31:0] exp_words[$];

    vec_t vecs[3];
    hdr_t h1, h;

    always #5 clk = ~clk;

    udp_ip_encoder dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .src_ip         (src_ip),
        .dest_ip        (dest_ip),
        .src_port       (src_port),
        .dest_port      (dest_port),
        .identification (identification),
        .time_to_live   (time_to_live),
        .len_data       (len_data),
        .data_in        (data_in),
        .rd_en          (rd_en),
        .data_out       (data_out),
        .wr_en          (wr_en),
        .busy           (busy),
        .fin            (fin),
        .err            (err)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=0x%08h expected=0x%08h", name, got, exp);
        end
    endtask

    task automatic refresh_data_in();
        data_in = (fifo.size() > 0) ? fifo[0] : 32'h0;
    endtask

    // Reference: the datagram as the protocol defines it, from header fields
    // and the payload words in pay_q.
    function automatic void build_expected(input hdr_t hh);
        logic [15:0] hw[10];
        logic [15:0] tl, cs;
        int unsigned sum;
        int          n, r;
        logic [31:0] w;
        tl = hh.len + 16'd28;
        hw = '{16'h4500, tl, hh.identification, 16'h4000, {hh.ttl, 8'd17}, 16'h0000,
               hh.src_ip[31:16], hh.src_ip[15:0], hh.dest_ip[31:16], hh.dest_ip[15:0]};
        sum = 0;
        for (int i = 0; i < 10; i++) sum += 32'(hw[i]);
        while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
        cs = ~sum[15:0];
        exp_words.delete();
        exp_words.push_back({16'h4500, tl});
        exp_words.push_back({hh.identification, 16'h4000});
        exp_words.push_back({hh.ttl, 8'd17, cs});
        exp_words.push_back(hh.src_ip);
        exp_words.push_back(hh.dest_ip);
        exp_words.push_back({hh.src_port, hh.dest_port});
        exp_words.push_back({hh.len + 16'd8, 16'h0000});
        n = (int'(hh.len) + 3) / 4;
        r = int'(hh.len) % 4;
        for (int i = 0; i < n; i++) begin
            w = pay_q[i];
            if (i == n - 1 && r != 0) w = w & (32'hFFFF_FFFF << (8 * (4 - r)));
            exp_words.push_back(w);
        end
    endfunction

    task automatic apply_stimulus(input hdr_t hh);
        foreach (pay_q[i]) fifo.push_back(pay_q[i]);
        refresh_data_in();
        @(negedge clk);
        src_ip         = hh.src_ip;
        dest_ip        = hh.dest_ip;
        src_port       = hh.src_port;
        dest_port      = hh.dest_port;
        identification = hh.identification;
        time_to_live   = hh.ttl;
        len_data       = hh.len;
        start          = 1'b1;
    endtask

    // Follows one datagram cycle by cycle after the accepting edge (c=1 is the
    // first sample after it) and compares against exp_words.
    task automatic check_output(input string name, input int exp_rd, input int restart_at);
        int          idx = 0, first_c = 0, fin_cnt = 0, fin_idx = -1;
        int          rd_cnt = 0, err_cnt = 0;
        logic        busy_c1 = 1'b0;
        bit          done = 1'b0, seen_busy = 1'b0;
        logic [31:0] hdr[5];
        int unsigned sum;
        for (int c = 1; c <= 3000 && !done; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start   = 1'b0;
                busy_c1 = busy;
            end
            if (busy) seen_busy = 1'b1;
            if (err) err_cnt++;
            if (wr_en) begin
                if (idx == 0) first_c = c;
                if (idx < 5) hdr[idx] = data_out;
                if (idx < exp_words.size())
                    check($sformatf("%s.w%0d", name, idx), data_out, exp_words[idx]);
                if (fin) fin_idx = idx;
                idx++;
            end
            if (fin) fin_cnt++;
            if (rd_en) begin
                rd_cnt++;
                if (fifo.size() > 0) void'(fifo.pop_front());
                refresh_data_in();
            end
            if (seen_busy && !busy) done = 1'b1;
            if (restart_at > 0 && c == restart_at) begin
                src_ip   = ~src_ip;
                len_data = 16'd8;
                start    = 1'b1;
            end
            if (restart_at > 0 && c == restart_at + 1) start = 1'b0;
        end
        check({name, ".done"}, 32'(done), 32'd1);
        check({name, ".busy_c1"}, 32'(busy_c1), 32'd1);
        check({name, ".n_words"}, 32'(idx), 32'(exp_words.size()));
        check({name, ".first_cycle"}, 32'(first_c), 32'd2);
        check({name, ".fin_count"}, 32'(fin_cnt), 32'd1);
        check({name, ".fin_pos"}, 32'(fin_idx), 32'(exp_words.size() - 1));
        check({name, ".rd_count"}, 32'(rd_cnt), 32'(exp_rd));
        check({name, ".err_count"}, 32'(err_cnt), 32'd0);
        check({name, ".fifo_left"}, 32'(fifo.size()), 32'd0);
        if (idx >= 5) begin
            sum = 0;
            for (int k = 0; k < 5; k++) sum += 32'(hdr[k][31:16]) + 32'(hdr[k][15:0]);
            while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
            check({name, ".hdr_sum"}, sum, 32'hFFFF);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; src_ip = '0; dest_ip = '0; src_port = '0;
        dest_port = '0; identification = '0; time_to_live = '0; len_data = '0; data_in = '0;
        repeat (3) @(negedge clk);
        check("reset.ctrl", 32'({rd_en, wr_en, busy, fin, err}), 32'd0);
        check("reset.data", data_out, 32'd0);
        reset = 1'b0;

        h1 = '{src_ip: 32'hC0A80001, dest_ip: 32'hC0A800C7, src_port: 16'd1234,
               dest_port: 16'd5678, identification: 16'd0, ttl: 8'h40, len: 16'd4};

        vecs[0].name = "t1_len4"; vecs[0].len = 16'd4; vecs[0].n_pay = 1;
        vecs[0].pay = '0; vecs[0].pay[0] = 32'hDEADBEEF; vecs[0].n_words = 8; vecs[0].exp_rd = 1;
        vecs[0].exp = '0;
        vecs[0].exp[0] = 32'h45000020; vecs[0].exp[1] = 32'h00004000; vecs[0].exp[2] = 32'h4011B8B4;
        vecs[0].exp[3] = 32'hC0A80001; vecs[0].exp[4] = 32'hC0A800C7; vecs[0].exp[5] = 32'h04D2162E;
        vecs[0].exp[6] = 32'h000C0000; vecs[0].exp[7] = 32'hDEADBEEF;

        vecs[1].name = "t2_len5"; vecs[1].len = 16'd5; vecs[1].n_pay = 2;
        vecs[1].pay[0] = 32'h11223344; vecs[1].pay[1] = 32'hAABBCCDD; vecs[1].n_words = 9; vecs[1].exp_rd = 2;
        vecs[1].exp[0] = 32'h45000021; vecs[1].exp[1] = 32'h00004000; vecs[1].exp[2] = 32'h4011B8B3;
        vecs[1].exp[3] = 32'hC0A80001; vecs[1].exp[4] = 32'hC0A800C7; vecs[1].exp[5] = 32'h04D2162E;
        vecs[1].exp[6] = 32'h000D0000; vecs[1].exp[7] = 32'h11223344; vecs[1].exp[8] = 32'hAA000000;

        vecs[2].name = "t3_len0"; vecs[2].len = 16'd0; vecs[2].n_pay = 0;
        vecs[2].pay = '0; vecs[2].n_words = 7; vecs[2].exp_rd = 0;
        vecs[2].exp = '0;
        vecs[2].exp[0] = 32'h4500001C; vecs[2].exp[1] = 32'h00004000; vecs[2].exp[2] = 32'h4011B8B8;
        vecs[2].exp[3] = 32'hC0A80001; vecs[2].exp[4] = 32'hC0A800C7; vecs[2].exp[5] = 32'h04D2162E;
        vecs[2].exp[6] = 32'h00080000;

        for (int v = 0; v < 3; v++) begin
            h = h1;
            h.len = vecs[v].len;
            pay_q.delete();
            for (int i = 0; i < vecs[v].n_pay; i++) pay_q.push_back(vecs[v].pay[i]);
            exp_words.delete();
            for (int i = 0; i < vecs[v].n_words; i++) exp_words.push_back(vecs[v].exp[i]);
            apply_stimulus(h);
            check_output(vecs[v].name, vecs[v].exp_rd, 0);
        end

        // Oversized requests: one err pulse, nothing else moves.
        for (int t = 0; t < 2; t++) begin
            h = h1;
            h.len = (t == 0) ? 16'd1473 : 16'hFFFF;
            pay_q.delete();
            apply_stimulus(h);
            @(negedge clk);
            start = 1'b0;
            check($sformatf("err%0d.pulse", t), 32'(err), 32'd1);
            check($sformatf("err%0d.quiet", t), 32'({rd_en, wr_en, busy, fin}), 32'd0);
            @(negedge clk);
            check($sformatf("err%0d.one_cycle", t), 32'({err, busy, wr_en}), 32'd0);
        end

        // Largest legal payload right after a rejection.
        h = h1;
        h.len = 16'd1472;
        pay_q.delete();
        for (int i = 0; i < 368; i++) pay_q.push_back($urandom);
        build_expected(h);
        apply_stimulus(h);
        check_output("max_len", 368, 0);

        // A start during the payload must not disturb the datagram.
        h = h1;
        h.len = 16'd40;
        h.identification = 16'hBEEF;
        pay_q.delete();
        for (int i = 0; i < 10; i++) pay_q.push_back($urandom);
        build_expected(h);
        apply_stimulus(h);
        check_output("restart_ignored", 10, 12);

        // Reset while W3 is on the bus aborts immediately.
        h = h1;
        pay_q.delete();
        pay_q.push_back(32'hDEADBEEF);
        apply_stimulus(h);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        check("rst_mid.w3", data_out, 32'hC0A80001);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid.ctrl", 32'({rd_en, wr_en, busy, fin, err}), 32'd0);
        check("rst_mid.data", data_out, 32'd0);
        reset = 1'b0;
        begin
            int active = 0;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                if (fin || wr_en || busy) active++;
            end
            check("rst_mid.idle_after", 32'(active), 32'd0);
        end
        fifo.delete();
        refresh_data_in();
        pay_q.delete();
        pay_q.push_back(32'hDEADBEEF);
        exp_words.delete();
        for (int i = 0; i < 8; i++) exp_words.push_back(vecs[0].exp[i]);
        apply_stimulus(h1);
        check_output("after_reset", 1, 0);

        // Random headers and payloads against the reference model.
        for (int i = 0; i < 1000; i++) begin
            h.src_ip         = $urandom;
            h.dest_ip        = $urandom;
            h.src_port       = 16'($urandom);
            h.dest_port      = 16'($urandom);
            h.identification = 16'($urandom);
            h.ttl            = 8'($urandom);
            if (i % 100 == 99) h.len = 16'($urandom_range(1400, 1472));
            else               h.len = 16'($urandom_range(0, 24));
            pay_q.delete();
            for (int k = 0; k < (int'(h.len) + 3) / 4; k++) pay_q.push_back($urandom);
            build_expected(h);
            apply_stimulus(h);
            check_output($sformatf("rand%0d", i), (int'(h.len) + 3) / 4, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
